// File: rtl/run_ctrl.sv
// run_ctrl: idle/run/done sequencer issuing len_i step requests over a req/ack handshake.
// Optional watchdog enabled by defining RUN_CTRL_TIMEOUT_EN.
module run_ctrl #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             abort_i,
    input  logic             clear_i,
    output logic             step_req_o,
    input  logic             step_ack_i,
    output logic [CNT_W-1:0] step_idx_o,
    output logic             idle_o,
    output logic             run_o,
    output logic             done_o,
    output logic             err_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             err_q, err_d;
    logic             hs;
    logic             last_step;

`ifdef RUN_CTRL_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_expire;

    assign wd_expire = (wd_q == WD_W'(TIMEOUT - 1));
`endif

    assign hs        = step_req_o & step_ack_i;
    assign last_step = (idx_q == (len_q - CNT_W'(1)));

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        err_d   = err_q;
`ifdef RUN_CTRL_TIMEOUT_EN
        wd_d    = wd_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    len_d   = len_i;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = (len_i != '0) ? ST_RUN : ST_DONE;
`ifdef RUN_CTRL_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end
            end
            ST_RUN: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end else if (hs) begin
`ifdef RUN_CTRL_TIMEOUT_EN
                    wd_d = '0;
`endif
                    if (last_step) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
`ifdef RUN_CTRL_TIMEOUT_EN
                else begin
                    wd_d = wd_q + WD_W'(1);
                    if (wd_expire) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end
                end
`endif
            end
            ST_DONE: begin
                // Start takes priority over clear; abort acts as clear here
                if (start_i) begin
                    len_d   = len_i;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = (len_i != '0) ? ST_RUN : ST_DONE;
`ifdef RUN_CTRL_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end else if (clear_i || abort_i) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

`ifdef RUN_CTRL_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    // Status decoded purely from state registers
    assign run_o      = (state_q == ST_RUN);
    assign done_o     = (state_q == ST_DONE);
    assign idle_o     = ~(run_o | done_o);
    assign step_req_o = run_o;
    assign step_idx_o = idx_q;
`ifdef RUN_CTRL_TIMEOUT_EN
    assign err_o      = err_q;
`else
    assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Directed scoreboard bench for run_ctrl; expected status is queued per cycle and popped after each edge.
module tb_run_ctrl;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned ST_I  = 0;
    localparam int unsigned ST_R  = 1;
    localparam int unsigned ST_D  = 2;

    typedef struct {
        string          tag;
        logic           idle;
        logic           run;
        logic           done;
        logic           req;
        logic [CNT_W-1:0] idx;
        logic           err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic [CNT_W-1:0] len_i;
    logic             abort_i;
    logic             clear_i;
    logic             step_req_o;
    logic             step_ack_i;
    logic [CNT_W-1:0] step_idx_o;
    logic             idle_o;
    logic             run_o;
    logic             done_o;
    logic             err_o;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    run_ctrl #(.CNT_W(CNT_W), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .len_i      (len_i),
        .abort_i    (abort_i),
        .clear_i    (clear_i),
        .step_req_o (step_req_o),
        .step_ack_i (step_ack_i),
        .step_idx_o (step_idx_o),
        .idle_o     (idle_o),
        .run_o      (run_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int unsigned st, input int unsigned idx, input logic err);
        exp_t e;
        e.tag  = tag;
        e.idle = (st == ST_I);
        e.run  = (st == ST_R);
        e.done = (st == ST_D);
        e.req  = (st == ST_R);
        e.idx  = CNT_W'(idx);
        e.err  = err;
        sb.push_back(e);
    endtask

    // Advance one edge, then compare the DUT against the oldest queued expectation
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        n_assert++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries expected at least 1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.tag, ".idle"}, 32'(idle_o),     32'(e.idle));
            check({e.tag, ".run"},  32'(run_o),      32'(e.run));
            check({e.tag, ".done"}, 32'(done_o),     32'(e.done));
            check({e.tag, ".req"},  32'(step_req_o), 32'(e.req));
            check({e.tag, ".idx"},  32'(step_idx_o), 32'(e.idx));
            check({e.tag, ".err"},  32'(err_o),      32'(e.err));
        end
    endtask

    task automatic step(input string tag, input int unsigned st, input int unsigned idx, input logic err);
        push(tag, st, idx, err);
        cycle();
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; len_i = '0; abort_i = 1'b0; clear_i = 1'b0; step_ack_i = 1'b0;
        step("reset0", ST_I, 0, 1'b0);
        step("reset1", ST_I, 0, 1'b0);
        rst = 1'b0;
        abort_i = 1'b1; clear_i = 1'b1;
        step("idle_abort_clear", ST_I, 0, 1'b0);
        abort_i = 1'b0; clear_i = 1'b0;

        // Basic run, ack tied high
        start_i = 1'b1; len_i = 8'd4; step_ack_i = 1'b1;
        step("basic_i0", ST_R, 0, 1'b0);
        start_i = 1'b0; len_i = 8'd9;
        for (int i = 1; i < 4; i++) step("basic_step", ST_R, i, 1'b0);
        step("basic_done", ST_D, 3, 1'b0);
        step("basic_hold", ST_D, 3, 1'b0);
        clear_i = 1'b1;
        step("basic_clear", ST_I, 0, 1'b0);
        clear_i = 1'b0; step_ack_i = 1'b0;

        // Backpressure: ack every third cycle
        start_i = 1'b1; len_i = 8'd3;
        step("bp_start", ST_R, 0, 1'b0);
        start_i = 1'b0;
        for (int h = 0; h < 3; h++) begin
            step("bp_wait", ST_R, h, 1'b0);
            step("bp_wait", ST_R, h, 1'b0);
            step_ack_i = 1'b1;
            if (h == 2) step("bp_done", ST_D, 2, 1'b0);
            else        step("bp_adv", ST_R, h + 1, 1'b0);
            step_ack_i = 1'b0;
        end
        clear_i = 1'b1;
        step("bp_clear", ST_I, 0, 1'b0);
        clear_i = 1'b0;

        // Zero length, then restart from DONE with start and clear together
        start_i = 1'b1; len_i = 8'd0;
        step("zero_done", ST_D, 0, 1'b0);
        len_i = 8'd2; clear_i = 1'b1; step_ack_i = 1'b1;
        step("restart_i0", ST_R, 0, 1'b0);
        start_i = 1'b0; clear_i = 1'b0;
        step("restart_i1", ST_R, 1, 1'b0);
        step("restart_done", ST_D, 1, 1'b0);
        step_ack_i = 1'b0; abort_i = 1'b1;
        step("done_abort", ST_I, 0, 1'b0);
        abort_i = 1'b0;

        // Abort with simultaneous ack at idx 6
        start_i = 1'b1; len_i = 8'd10; step_ack_i = 1'b1;
        step("abort_i0", ST_R, 0, 1'b0);
        start_i = 1'b0;
        for (int i = 1; i <= 6; i++) step("abort_step", ST_R, i, 1'b0);
        abort_i = 1'b1;
        step("abort_idle", ST_I, 0, 1'b0);
        abort_i = 1'b0; step_ack_i = 1'b0;
        step("abort_stay", ST_I, 0, 1'b0);

        // Start beats abort in IDLE; start ignored in RUN
        start_i = 1'b1; abort_i = 1'b1; len_i = 8'd1;
        step("start_wins", ST_R, 0, 1'b0);
        abort_i = 1'b0; len_i = 8'd5;
        step("run_ignores_start", ST_R, 0, 1'b0);
        start_i = 1'b0; step_ack_i = 1'b1;
        step("len1_done", ST_D, 0, 1'b0);
        clear_i = 1'b1; step_ack_i = 1'b0;
        step("len1_clear", ST_I, 0, 1'b0);
        clear_i = 1'b0;

        // Reset mid-run at idx 2
        start_i = 1'b1; len_i = 8'd5; step_ack_i = 1'b1;
        step("rst_i0", ST_R, 0, 1'b0);
        start_i = 1'b0;
        step("rst_i1", ST_R, 1, 1'b0);
        step("rst_i2", ST_R, 2, 1'b0);
        rst = 1'b1;
        step("rst_mid0", ST_I, 0, 1'b0);
        step("rst_mid1", ST_I, 0, 1'b0);
        rst = 1'b0; step_ack_i = 1'b0;
        step("rst_after", ST_I, 0, 1'b0);

`ifdef RUN_CTRL_TIMEOUT_EN
        // Watchdog: 8 RUN cycles without ack, then DONE with error
        start_i = 1'b1; len_i = 8'd2;
        step("to_run", ST_R, 0, 1'b0);
        start_i = 1'b0;
        for (int i = 1; i < 8; i++) step("to_wait", ST_R, 0, 1'b0);
        step("to_done", ST_D, 0, 1'b1);
        step("to_hold", ST_D, 0, 1'b1);
        clear_i = 1'b1;
        step("to_clear", ST_I, 0, 1'b0);
        clear_i = 1'b0;
`else
        // No watchdog: RUN waits for ack indefinitely
        start_i = 1'b1; len_i = 8'd2;
        step("nowd_run", ST_R, 0, 1'b0);
        start_i = 1'b0;
        for (int i = 0; i < 20; i++) step("nowd_wait", ST_R, 0, 1'b0);
        abort_i = 1'b1;
        step("nowd_abort", ST_I, 0, 1'b0);
        abort_i = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
